// File: rtl/fp_defs.sv
// Shared floating-point datapath definitions: operand width, arbiter FSM states, op tag.
package fp_defs;

    localparam int C_OP     = 16;
    localparam int TAG_ID_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fp_arb_state_e;

    // id is sized for the largest supported requester count (16).
    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } fp_tag_t;

endpackage

// File: rtl/fp_add_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
// Zero latency; grant_o is one-hot or all-zero.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int n = 0; n < NUM_REQ; n++) begin
                if (!found && req_i[n] && (((int'(ptr_i) + i) % NUM_REQ) == n)) begin
                    found      = 1'b1;
                    grant_o[n] = 1'b1;
                    idx_o      = ID_W'(n);
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin share of one fp adder; fire to rsp_valid_o is ADD_LAT+1 cycles, 1 op/cycle,
// no response backpressure. flush_i drains the pipe. FP_ARB_STATS_EN adds grant counters.
module fp_add_arbiter
    import fp_defs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1,
    parameter int C_OP    = fp_defs::C_OP
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*C_OP-1:0] req_a_i,
    input  logic [NUM_REQ*C_OP-1:0] req_b_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [C_OP-1:0]         rsp_data_o,
    output logic [C_OP-1:0]         add_a_o,
    output logic [C_OP-1:0]         add_b_o,
    input  logic [C_OP-1:0]         add_res_i,
    input  logic                    flush_i,
`ifdef FP_ARB_STATS_EN
    input  logic                    stat_clr_i,
    output logic [NUM_REQ*16-1:0]   stat_cnt_o,
`endif
    output logic                    idle_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    fp_arb_state_e       state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [C_OP-1:0]     add_a_q, add_b_q, rsp_data_q;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    fp_tag_t             tag_q [ADD_LAT];
    fp_tag_t             tag_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_idx;
    logic                win_any;
    logic                fire;
    logic                pipe_busy;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // flush_i gates grants in the same cycle it rises, before the FSM has moved.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        fire        = 1'b0;
        ptr_d       = ptr_q;
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else begin
                    req_ready_o = grant;
                    fire        = win_any;
                end
            end
            DRAIN: begin
                if (!flush_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (fire) ptr_d = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
        tag_d.vld = fire;
        tag_d.id  = TAG_ID_W'(win_idx);
    end

    always_comb begin
        rsp_valid_d = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (tag_q[ADD_LAT-1].vld && tag_q[ADD_LAT-1].id == TAG_ID_W'(n)) rsp_valid_d[n] = 1'b1;
        end
        // The response register counts as the final pipe stage for idle.
        pipe_busy = |rsp_valid_q;
        for (int i = 0; i < ADD_LAT; i++) pipe_busy = pipe_busy | tag_q[i].vld;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            for (int i = 0; i < ADD_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            if (fire) begin
                add_a_q <= req_a_i[win_idx*C_OP +: C_OP];
                add_b_q <= req_b_i[win_idx*C_OP +: C_OP];
            end
            if (tag_q[ADD_LAT-1].vld) rsp_data_q <= add_res_i;
            tag_q[0] <= tag_d;
            for (int i = 1; i < ADD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

`ifdef FP_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_REQ; n++) cnt_q[n] <= '0;
        end else if (stat_clr_i) begin
            for (int n = 0; n < NUM_REQ; n++) cnt_q[n] <= '0;
        end else if (fire && cnt_q[win_idx] != 16'hFFFF) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + 16'd1;
        end
    end

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_stat
        assign stat_cnt_o[n*16 +: 16] = cnt_q[n];
    end
`endif

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign idle_o      = (state_q == DRAIN) && !pipe_busy;

endmodule
